// File: rtl/alu_exec_pkg.sv
// Shared definitions for the alu_exec block: FSM state encoding, ALU op codes,
// operand-B shift codes and the shift helper.
// Build option: ALU_EXEC_SHIFTER_EN enables the operand-B shifter helper.
package alu_exec_pkg;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_GETA  = 3'd1,
        ST_GETB  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] AND  = 2'b10;
    localparam logic [1:0] NOTB = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

`ifdef ALU_EXEC_SHIFTER_EN
    function automatic logic [15:0] shift_b(input logic [15:0] b, input logic [1:0] code);
        logic [15:0] r;
        case (code)
            SH_LSL:  r = {b[14:0], 1'b0};
            SH_LSR:  r = {1'b0, b[15:1]};
            SH_ASR:  r = {b[15], b[15:1]};
            default: r = b;
        endcase
        return r;
    endfunction
`endif

endpackage

// File: rtl/alu.sv
// Existing 16-bit ALU: add, subtract, and, invert-B; Z flags a zero result.
module alu (
    input  logic [15:0] ain,
    input  logic [15:0] bin,
    input  logic [1:0]  alu_op,
    output logic [15:0] out,
    output logic        z
);

    // Result select; carry-out is dropped, arithmetic wraps at 16 bits.
    always_comb begin
        case (alu_op)
            2'b00:   out = ain + bin;
            2'b01:   out = ain - bin;
            2'b10:   out = ain & bin;
            default: out = ~bin;
        endcase
    end

    assign z = (out == 16'd0);

endmodule

// File: rtl/regfile8x16.sv
// Eight 16-bit registers: one synchronous write port, two combinational reads.
module regfile8x16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [2:0]  w_num,
    input  logic [15:0] w_data,
    input  logic [2:0]  ra_num,
    output logic [15:0] ra_data,
    input  logic [2:0]  rb_num,
    output logic [15:0] rb_data
);

    logic [15:0] regs [8];

    // Storage: synchronous clear on active-low reset, else single write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
        end else if (we) begin
            regs[w_num] <= w_data;
        end
    end

    assign ra_data = regs[ra_num];
    assign rb_data = regs[rb_num];

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle execute unit: fetch A, fetch B, run the ALU, write back to R[rd].
// Build option: ALU_EXEC_SHIFTER_EN adds the operand-B shifter; without it Bs = B.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_WAIT  | idle, w=1; external writes accepted, s starts an operation
// ST_GETA  | load A from R[rn]
// ST_GETB  | load B from R[rm]
// ST_EXEC  | load C and status from the ALU
// ST_WRITE | done=1; R[rd] <= C
module alu_exec
    import alu_exec_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [1:0]  op,
    input  logic [2:0]  rd,
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [1:0]  shift,
    input  logic        wr_en,
    input  logic [2:0]  wr_num,
    input  logic [15:0] wr_data,
    input  logic [2:0]  rd_num,
    output logic [15:0] rd_data,
    output logic        w,
    output logic        done,
    output logic [2:0]  status,
    output logic [15:0] c_out
);

    state_t      state, next_state;
    logic [1:0]  op_q;
    logic [2:0]  rd_q, rn_q, rm_q;
    logic [15:0] a_q, b_q, c_q;
    logic [15:0] bs, alu_res, op_data;
    logic        alu_z, v_flag;
    logic        capture, load_a, load_b, load_c;
    logic        rf_we;
    logic [2:0]  rf_wnum, op_num;
    logic [15:0] rf_wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_WAIT;
        else        state <= next_state;
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        next_state = state;
        w          = 1'b0;
        done       = 1'b0;
        capture    = 1'b0;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_c     = 1'b0;
        case (state)
            ST_WAIT: begin
                w       = 1'b1;
                capture = s;
                if (s) next_state = ST_GETA;
            end
            ST_GETA: begin
                load_a     = 1'b1;
                next_state = ST_GETB;
            end
            ST_GETB: begin
                load_b     = 1'b1;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                load_c     = 1'b1;
                next_state = ST_WRITE;
            end
            ST_WRITE: begin
                done       = 1'b1;
                next_state = ST_WAIT;
            end
            default: next_state = ST_WAIT;
        endcase
    end

`ifdef ALU_EXEC_SHIFTER_EN
    logic [1:0] shift_q;

    // Shift code travels with the rest of the captured command.
    always_ff @(posedge clk) begin
        if (!reset)       shift_q <= SH_NONE;
        else if (capture) shift_q <= shift;
    end

    assign bs = shift_b(b_q, shift_q);
`else
    logic shift_unused;
    assign shift_unused = ^shift;
    assign bs           = b_q;
`endif

    // Command capture and A/B/C/status datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q   <= ADD;
            rd_q   <= 3'd0;
            rn_q   <= 3'd0;
            rm_q   <= 3'd0;
            a_q    <= 16'd0;
            b_q    <= 16'd0;
            c_q    <= 16'd0;
            status <= 3'b000;
        end else begin
            if (capture) begin
                op_q <= op;
                rd_q <= rd;
                rn_q <= rn;
                rm_q <= rm;
            end
            if (load_a) a_q <= op_data;
            if (load_b) b_q <= op_data;
            if (load_c) begin
                c_q    <= alu_res;
                status <= {alu_res[15], v_flag, alu_z};
            end
        end
    end

    // Signed overflow only has meaning for add and subtract.
    always_comb begin
        case (op_q)
            ADD:     v_flag = (a_q[15] == bs[15]) && (alu_res[15] != a_q[15]);
            SUB:     v_flag = (a_q[15] != bs[15]) && (alu_res[15] != a_q[15]);
            default: v_flag = 1'b0;
        endcase
    end

    alu u_alu (
        .ain    (a_q),
        .bin    (bs),
        .alu_op (op_q),
        .out    (alu_res),
        .z      (alu_z)
    );

    // Writeback owns the write port in WRITE; the external port only in WAIT.
    assign rf_we    = (state == ST_WRITE) || ((state == ST_WAIT) && wr_en);
    assign rf_wnum  = (state == ST_WRITE) ? rd_q : wr_num;
    assign rf_wdata = (state == ST_WRITE) ? c_q  : wr_data;
    assign op_num   = (state == ST_GETA)  ? rn_q : rm_q;

    regfile8x16 u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .w_num   (rf_wnum),
        .w_data  (rf_wdata),
        .ra_num  (rd_num),
        .ra_data (rd_data),
        .rb_num  (op_num),
        .rb_data (op_data)
    );

    assign c_out = c_q;

endmodule
